// File: rtl/hangman_pkg.sv
// hangman_pkg: shared encodings for the hangman game sequencer and its datapath.
package hangman_pkg;
  typedef enum logic [1:0] {GS_PLAY = 2'd0, GS_LOSE = 2'd1, GS_WIN = 2'd2, GS_IDLE = 2'd3} game_state_t;
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_CHECK, S_FB, S_LOSE, S_WIN} fsm_t;
  localparam logic [5:0] CODE_MIN  = 6'h0A;
  localparam logic [5:0] CODE_MAX  = 6'h23;
  localparam logic [5:0] CODE_DASH = 6'h00;
  function automatic logic legal_code(input logic [5:0] c);
    return (c >= CODE_MIN) && (c <= CODE_MAX);
  endfunction
endpackage

// File: rtl/hangman_game_sequencer_if.sv
// hangman_game_sequencer_if: board/datapath signals of the game sequencer.
interface hangman_game_sequencer_if #(parameter int NUM_WORDS = 5);
  localparam int WSW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  logic           start;
  logic [5:0]     guess_code;
  logic           guess_commit;
  logic           dp_hit;
  logic           dp_complete;
  logic           dp_clear;
  logic           dp_strobe;
  logic [5:0]     dp_guess;
  logic [WSW-1:0] word_sel;
  logic [3:0]     wrong_count;
  logic           fb_hit;
  logic           fb_miss;
  logic           fb_reject;
  logic [1:0]     game_state;
  modport master (
    output start, guess_code, guess_commit, dp_hit, dp_complete,
    input  dp_clear, dp_strobe, dp_guess, word_sel, wrong_count, fb_hit, fb_miss, fb_reject, game_state
  );
  modport slave (
    input  start, guess_code, guess_commit, dp_hit, dp_complete,
    output dp_clear, dp_strobe, dp_guess, word_sel, wrong_count, fb_hit, fb_miss, fb_reject, game_state
  );
endinterface

// File: rtl/hangman_edge_det.sv
// hangman_edge_det: rising-edge detector for a clk-synchronous level input.
module hangman_edge_det (
  input  logic clk,
  input  logic resetn,
  input  logic i_in,
  output logic o_rise
);
  logic r_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_q <= 1'b0;
    else r_q <= i_in;
  assign o_rise = i_in & ~r_q;
endmodule

// File: rtl/hangman_game_sequencer.sv
// hangman_game_sequencer: word select, guess validation, miss counting and WIN/LOSE control.
// Optional GUESS_TIMEOUT_EN: an idle WAIT_GUESS lasting TIMEOUT_CYCLES counts as a miss.
module hangman_game_sequencer
  import hangman_pkg::*;
#(
  parameter int NUM_WORDS       = 5,
  parameter int MAX_WRONG       = 4,
  parameter int FEEDBACK_CYCLES = 12_500_000,
  parameter int TIMEOUT_CYCLES  = 500_000_000
) (
  input  logic clk,
  input  logic resetn,
  hangman_game_sequencer_if.slave bus
);
  localparam int WSW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int FBW = $clog2(FEEDBACK_CYCLES);

  if (MAX_WRONG < 1 || MAX_WRONG > 15 || FEEDBACK_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("hangman_game_sequencer: parameter out of range");
  end

  logic            w_start_rise, w_commit_rise, w_timeout;
  fsm_t            r_state;
  game_state_t     r_gs;
  logic [WSW-1:0]  r_word_cnt, r_word_sel;
  logic [FBW-1:0]  r_fb_cnt;
  logic [63:0]     r_guessed;
  logic [5:0]      r_dp_guess;
  logic [3:0]      r_wrong;
  logic            r_clear, r_strobe, r_fb_hit, r_fb_miss, r_fb_reject;
  logic [3:0]      w_wrong_inc;

  hangman_edge_det u_start_ed  (.clk(clk), .resetn(resetn), .i_in(bus.start),        .o_rise(w_start_rise));
  hangman_edge_det u_commit_ed (.clk(clk), .resetn(resetn), .i_in(bus.guess_commit), .o_rise(w_commit_rise));

  assign w_wrong_inc = (r_wrong == 4'hF) ? 4'hF : r_wrong + 4'd1;

`ifdef GUESS_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TOW-1:0] r_to_cnt;
  // Anything other than an idle WAIT_GUESS cycle restarts the count.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_to_cnt <= '0;
    else r_to_cnt <= (r_state == S_WAIT && !w_commit_rise && !w_start_rise) ? r_to_cnt + 1'b1 : '0;
  assign w_timeout = (r_state == S_WAIT) && (r_to_cnt == TOW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_gs        <= GS_IDLE;
      r_word_cnt  <= '0;
      r_word_sel  <= '0;
      r_fb_cnt    <= '0;
      r_guessed   <= '0;
      r_dp_guess  <= CODE_DASH;
      r_wrong     <= '0;
      r_clear     <= 1'b0;
      r_strobe    <= 1'b0;
      r_fb_hit    <= 1'b0;
      r_fb_miss   <= 1'b0;
      r_fb_reject <= 1'b0;
    end else begin
      r_word_cnt <= (r_word_cnt == WSW'(NUM_WORDS - 1)) ? '0 : r_word_cnt + 1'b1;
      r_clear    <= 1'b0;
      r_strobe   <= 1'b0;
      if (w_start_rise) begin
        r_state    <= S_ARM;
        r_gs       <= GS_PLAY;
        r_word_sel <= r_word_cnt;
        r_clear    <= 1'b1;
        r_wrong    <= '0;
        r_guessed  <= '0;
        {r_fb_hit, r_fb_miss, r_fb_reject} <= 3'b000;
      end else begin
        case (r_state)
          S_ARM: r_state <= S_WAIT;
          S_WAIT:
            if (w_commit_rise) begin
              if (!legal_code(bus.guess_code) || r_guessed[bus.guess_code]) begin
                r_state     <= S_FB;
                r_fb_reject <= 1'b1;
                r_fb_cnt    <= FBW'(FEEDBACK_CYCLES - 1);
              end else begin
                r_state                  <= S_CHECK;
                r_dp_guess               <= bus.guess_code;
                r_guessed[bus.guess_code] <= 1'b1;
                r_strobe                 <= 1'b1;
              end
            end else if (w_timeout) begin
              r_state   <= S_FB;
              r_fb_miss <= 1'b1;
              r_wrong   <= w_wrong_inc;
              r_fb_cnt  <= FBW'(FEEDBACK_CYCLES - 1);
            end
          S_CHECK: begin
            r_state   <= S_FB;
            r_fb_cnt  <= FBW'(FEEDBACK_CYCLES - 1);
            r_fb_hit  <= bus.dp_hit;
            r_fb_miss <= !bus.dp_hit;
            r_wrong   <= bus.dp_hit ? r_wrong : w_wrong_inc;
          end
          S_FB:
            if (r_fb_cnt == '0) begin
              {r_fb_hit, r_fb_miss, r_fb_reject} <= 3'b000;
              r_state <= (r_wrong == 4'(MAX_WRONG)) ? S_LOSE : bus.dp_complete ? S_WIN : S_WAIT;
              r_gs    <= (r_wrong == 4'(MAX_WRONG)) ? GS_LOSE : bus.dp_complete ? GS_WIN : GS_PLAY;
            end else r_fb_cnt <= r_fb_cnt - 1'b1;
          default: r_state <= r_state;
        endcase
      end
    end

  assign bus.dp_clear    = r_clear;
  assign bus.dp_strobe   = r_strobe;
  assign bus.dp_guess    = r_dp_guess;
  assign bus.word_sel    = r_word_sel;
  assign bus.wrong_count = r_wrong;
  assign bus.fb_hit      = r_fb_hit;
  assign bus.fb_miss     = r_fb_miss;
  assign bus.fb_reject   = r_fb_reject;
  assign bus.game_state  = r_gs;
endmodule

// File: tb/tb_hangman_game_sequencer.sv
// tb_hangman_game_sequencer: directed and randomized guesses against a per-guess game model.
module tb_hangman_game_sequencer;
  localparam int NW = 5, MW = 4, FC = 4, TO = 10;

  logic clk = 1'b0;
  logic resetn;
  int n_chk = 0, n_pass = 0;
  int m_cnt, m_wrong, m_gs;
  bit m_used[64];

  always #5 clk = ~clk;

  hangman_game_sequencer_if #(.NUM_WORDS(NW)) bus ();
  hangman_game_sequencer #(.NUM_WORDS(NW), .MAX_WRONG(MW), .FEEDBACK_CYCLES(FC), .TIMEOUT_CYCLES(TO))
    dut (.clk(clk), .resetn(resetn), .bus(bus));

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) m_cnt <= 0;
    else m_cnt <= (m_cnt + 1) % NW;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gs"}, bus.game_state, 3);
    chk({tag, "_pulses"}, {bus.dp_clear, bus.dp_strobe, bus.fb_hit, bus.fb_miss, bus.fb_reject}, 0);
    chk({tag, "_wrong"}, bus.wrong_count, 0);
    chk({tag, "_guess"}, bus.dp_guess, 0);
    chk({tag, "_wsel"}, bus.word_sel, 0);
  endtask

  task automatic model_new_game();
    m_wrong = 0;
    m_gs = 0;
    foreach (m_used[i]) m_used[i] = 1'b0;
  endtask

  task automatic do_start();
    int ws;
    ws = m_cnt;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    model_new_game();
    chk("start_clear", bus.dp_clear, 1);
    chk("start_wsel", bus.word_sel, ws);
    chk("start_fb", {bus.fb_hit, bus.fb_miss, bus.fb_reject}, 0);
    chk("start_wrong", bus.wrong_count, 0);
    chk("start_gs", bus.game_state, 0);
    @(negedge clk);
    chk("clear_width", bus.dp_clear, 0);
  endtask

  // kind: 0 ignored, 1 hit, 2 miss, 3 reject
  task automatic do_guess(input logic [5:0] code, input bit hit, input bit comp);
    int kind;
    logic [3:0] e, fbv;
    bit acc;
    if (m_gs != 0) kind = 0;
    else if (code < 6'h0A || code > 6'h23 || m_used[code]) kind = 3;
    else begin
      m_used[code] = 1'b1;
      kind = hit ? 1 : 2;
      if (!hit) m_wrong = (m_wrong < 15) ? m_wrong + 1 : 15;
    end
    acc = (kind == 1) || (kind == 2);
    fbv = (kind == 1) ? 4'b0100 : (kind == 2) ? 4'b0010 : 4'b0001;
    bus.guess_code = code;
    bus.dp_hit = hit;
    bus.dp_complete = comp;
    bus.guess_commit = 1'b1;
    for (int k = 1; k <= FC + 2; k++) begin
      @(negedge clk);
      if (k == 1) bus.guess_commit = 1'b0;
      e = acc ? {k == 1, (k >= 2 && k <= FC + 1) ? fbv[2:0] : 3'b000}
        : (kind == 3 && k <= FC) ? 4'b0001 : 4'b0000;
      chk($sformatf("cyc%0d_code%0h", k, code), {bus.dp_strobe, bus.fb_hit, bus.fb_miss, bus.fb_reject}, e);
      if (k == 1 && acc) chk("dp_guess", bus.dp_guess, code);
    end
    if (kind != 0) m_gs = (m_wrong == MW) ? 1 : comp ? 2 : 0;
    chk("wrong_count", bus.wrong_count, m_wrong);
    chk("game_state", bus.game_state, m_gs);
  endtask

  initial begin
    int n;
    resetn = 1'b0;
    bus.start = 1'b0;
    bus.guess_code = '0;
    bus.guess_commit = 1'b0;
    bus.dp_hit = 1'b0;
    bus.dp_complete = 1'b0;
    m_gs = 3;
    m_wrong = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    resetn = 1'b1;
    n = 0;
    while (m_cnt != 3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cnt_reach3", m_cnt, 3);
    do_start();
    chk("wsel_is3", bus.word_sel, 3);
    do_guess(6'h1C, 1'b1, 1'b0);
    do_guess(6'h1C, 1'b1, 1'b0);
    do_guess(6'h05, 1'b0, 1'b0);
    do_guess(6'h0A, 1'b0, 1'b0);
    do_guess(6'h0B, 1'b0, 1'b0);
    do_guess(6'h0C, 1'b0, 1'b0);
    do_guess(6'h23, 1'b0, 1'b0);
    chk("lose_state", bus.game_state, 1);
    do_guess(6'h0E, 1'b1, 1'b0);
    do_start();
    do_guess(6'h20, 1'b0, 1'b0);
    do_guess(6'h10, 1'b1, 1'b1);
    chk("win_state", bus.game_state, 2);
    do_start();
    // restart while a miss is being shown
    bus.guess_code = 6'h11;
    bus.dp_hit = 1'b0;
    bus.dp_complete = 1'b0;
    bus.guess_commit = 1'b1;
    @(negedge clk);
    bus.guess_commit = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_fb_miss", bus.fb_miss, 1);
    chk("mid_fb_wrong", bus.wrong_count, 1);
    do_start();
    do_guess(6'h11, 1'b1, 1'b0);
    bus.guess_code = 6'h12;
    bus.dp_hit = 1'b1;
    bus.guess_commit = 1'b1;
    @(negedge clk);
    bus.guess_commit = 1'b0;
    chk("check_strobe", bus.dp_strobe, 1);
    #2 resetn = 1'b0;
    #1 chk_reset_outputs("async_reset");
    @(negedge clk);
    resetn = 1'b1;
    m_gs = 3;
    do_guess(6'h13, 1'b1, 1'b0);
    for (int g = 0; g < 40; g++) begin
      if (m_gs != 0 || $urandom_range(0, 11) == 0) do_start();
      do_guess(($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(10, 35)),
               1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
    end
    do_start();
    n = 0;
    begin
      int first_miss = 0;
      bit strobe_seen = 1'b0;
      while (n < 20) begin
        @(negedge clk);
        n++;
        strobe_seen |= bus.dp_strobe;
        if (bus.fb_miss && first_miss == 0) first_miss = n;
      end
`ifdef GUESS_TIMEOUT_EN
      chk("timeout_delay", first_miss, TO);
      chk("timeout_wrong", bus.wrong_count, 1);
`else
      chk("no_timeout", first_miss, 0);
      chk("no_timeout_gs", bus.game_state, 0);
`endif
      chk("timeout_nostrobe", strobe_seen, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
